// File: rtl/mio_wait_responder.sv
// Wait-state responder on the CPU MIO bus: address-window decode, 2^ADDR_W x 32 register bank,
// WAIT_CYCLES stall before a one-cycle MIO_ready pulse. Optional macro: WAIT_STATS_EN.
module mio_wait_responder #(
    parameter logic [3:0] BASE_NIB    = 4'hD,
    parameter int         ADDR_W      = 4,
    parameter int         WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] addr_bus,
    input  logic [31:0] Cpu_data2bus,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        MIO_ready,
    output logic        busy,
    output logic [1:0]  dbg_state
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] TOP_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [7:0] CNT_INIT = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_ACK     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // Handshake: CPU holds CPU_MIO with stable addr/data/mem_w until it sees MIO_ready;
    // MIO_ready is high for exactly the ACK cycle, and the request must drop before another is taken.
    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]  idx_q;
    logic [31:0]        data_q;
    logic               we_q;
    logic [31:0]        bank_q [DEPTH];

    logic               latch_en;
    logic               load_rdata;
    logic [ADDR_W-1:0]  addr_idx;
    logic [ADDR_W-1:0]  rd_idx;
    logic               rd_we;
    logic [31:0]        rd_word;
    logic               unused_addr_bits;

    assign addr_idx         = addr_bus[ADDR_W+1:2];
    assign unused_addr_bits = ^{addr_bus[27:ADDR_W+2], addr_bus[1:0]};
    assign hit              = CPU_MIO & (addr_bus[31:28] == BASE_NIB);
    assign MIO_ready        = (state_q == S_ACK);
    assign busy             = (state_q != S_IDLE);
    assign dbg_state        = state_q;

    // With zero wait the read is captured straight from the live bus on the IDLE->ACK edge.
    assign rd_idx = (state_q == S_IDLE) ? addr_idx : idx_q;
    assign rd_we  = (state_q == S_IDLE) ? mem_w    : we_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latch_en   = 1'b0;
        load_rdata = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    latch_en = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_ACK;
                        load_rdata = 1'b1;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d    = S_ACK;
                    load_rdata = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_ACK: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!CPU_MIO) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef WAIT_STATS_EN
    logic [31:0] stat_q;
    logic [31:0] stat_nxt;

    // stat_nxt already includes the current WAIT cycle, so a read sees the count as of ACK.
    always_comb begin
        stat_nxt = stat_q;
        if (state_q == S_WAIT && stat_q != 32'hFFFF_FFFF) stat_nxt = stat_q + 32'd1;
    end

    assign rd_word = (rd_idx == TOP_IDX) ? stat_nxt : bank_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= 32'd0;
        end else if (state_q == S_ACK && we_q && idx_q == TOP_IDX) begin
            stat_q <= 32'd0;
        end else begin
            stat_q <= stat_nxt;
        end
    end
`else
    assign rd_word = bank_q[rd_idx];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            data_q  <= 32'd0;
            we_q    <= 1'b0;
            rdata   <= 32'd0;
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                idx_q  <= addr_idx;
                data_q <= Cpu_data2bus;
                we_q   <= mem_w;
            end
            if (load_rdata && !rd_we) rdata <= rd_word;
`ifdef WAIT_STATS_EN
            if (state_q == S_ACK && we_q && idx_q != TOP_IDX) bank_q[idx_q] <= data_q;
`else
            if (state_q == S_ACK && we_q) bank_q[idx_q] <= data_q;
`endif
        end
    end
endmodule

// File: tb/tb_mio_wait_responder.sv
// Randomized self-checking bench for mio_wait_responder against a word-level bank model.
module tb_mio_wait_responder;
  localparam int W     = 3;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef WAIT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cpu_mio, mem_w;
  logic [31:0] addr, wdata;
  logic        hit, ready, busy;
  logic [31:0] rdata;
  logic [1:0]  dbg;

  logic        cpu_mio0, mem_w0;
  logic [31:0] addr0, wdata0;
  logic        hit0, ready0, busy0;
  logic [31:0] rdata0;
  logic [1:0]  dbg0;

  mio_wait_responder #(.BASE_NIB(4'hD), .ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .CPU_MIO(cpu_mio), .mem_w(mem_w), .addr_bus(addr),
    .Cpu_data2bus(wdata), .hit(hit), .rdata(rdata), .MIO_ready(ready), .busy(busy),
    .dbg_state(dbg));

  mio_wait_responder #(.BASE_NIB(4'hD), .ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .CPU_MIO(cpu_mio0), .mem_w(mem_w0), .addr_bus(addr0),
    .Cpu_data2bus(wdata0), .hit(hit0), .rdata(rdata0), .MIO_ready(ready0), .busy(busy0),
    .dbg_state(dbg0));

  int compared   = 0;
  int mismatched = 0;

  // reference model
  logic [31:0] model_bank [DEPTH];
  logic [31:0] model_rdata;
  logic [31:0] model_stat;
  logic [31:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_bank[i] = 32'd0;
    model_rdata = 32'd0;
    model_stat  = 32'd0;
  endtask

  // driver: one complete access on the WAIT_CYCLES=W instance
  task automatic do_access(input logic [31:0] a, input logic we, input logic [31:0] d,
                           input int drop_after, input string tag);
    int n;
    bit got;
    int idx;
    logic [31:0] exp;
    idx = int'(a[AW+1:2]);
    model_stat = (model_stat > 32'hFFFF_FFFF - W) ? 32'hFFFF_FFFF : model_stat + W;
    if (!we) begin
      exp = (STATS && idx == DEPTH - 1) ? model_stat : model_bank[idx];
      exp_q.push_back(exp);
    end
    cpu_mio = 1'b1; mem_w = we; addr = a; wdata = d;
    #1;
    compared++;
    if (hit !== 1'b1 || ready !== 1'b0) begin
      mismatched++;
      $display("FAIL %s req_start: hit=%b ready=%b required hit=1 ready=0", tag, hit, ready);
    end
    n = 0; got = 0;
    while (!got && n < 50) begin
      tick();
      n++;
      if (ready === 1'b1) got = 1;
      else if (n == drop_after) begin
        cpu_mio = 1'b0; addr = $urandom; wdata = $urandom; mem_w = ~we;
      end
    end
    compared++;
    if (!got || n != W + 1) begin
      mismatched++;
      $display("FAIL %s latency: got=%0d cycles=%0d required %0d", tag, got, n, W + 1);
    end
    if (!we) begin
      exp = exp_q.pop_front();
      compared++;
      if (rdata !== exp) begin
        mismatched++;
        $display("FAIL %s rdata: %h required %h (addr %h)", tag, rdata, exp, a);
      end
      model_rdata = exp;
    end else begin
      compared++;
      if (rdata !== model_rdata) begin
        mismatched++;
        $display("FAIL %s rdata_hold: %h required %h", tag, rdata, model_rdata);
      end
      if (STATS && idx == DEPTH - 1) model_stat = 32'd0;
      else model_bank[idx] = d;
    end
    cpu_mio = 1'b0;
    tick();
    compared++;
    if (ready !== 1'b0) begin
      mismatched++;
      $display("FAIL %s one_pulse: ready=%b required 0", tag, ready);
    end
    tick();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL %s back_idle: busy=%b required 0", tag, busy);
    end
  endtask

  // driver: out-of-window request, must never be answered
  task automatic do_miss(input logic [31:0] a, input string tag);
    int pulses;
    cpu_mio = 1'b1; mem_w = 1'b1; addr = a; wdata = $urandom;
    #1;
    compared++;
    if (hit !== 1'b0) begin
      mismatched++;
      $display("FAIL %s miss_hit: hit=%b required 0 (addr %h)", tag, hit, a);
    end
    pulses = 0;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (ready !== 1'b0 || busy !== 1'b0) pulses++;
    end
    compared++;
    if (pulses != 0) begin
      mismatched++;
      $display("FAIL %s miss_quiet: active_cycles=%0d required 0", tag, pulses);
    end
    cpu_mio = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    compared++;
    if (ready !== 1'b0 || busy !== 1'b0 || rdata !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: ready=%b busy=%b rdata=%h required 0/0/0", ready, busy, rdata);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) do_access(32'hD000_0000 + 4 * i, 1'b0, 32'd0, 0, "reset_read");
  endtask

  task automatic test_write_read();
    do_access(32'hD000_0008, 1'b1, 32'hDEAD_BEEF, 0, "wr_deadbeef");
    do_access(32'hD000_0008, 1'b0, 32'd0, 0, "rd_deadbeef");
    do_access(32'hDFFF_FFCB, 1'b0, 32'd0, 0, "rd_alias");
  endtask

  task automatic test_zero_wait();
    int pulses;
    cpu_mio0 = 1'b1; mem_w0 = 1'b1; addr0 = 32'hD000_0004; wdata0 = 32'hA5A5_0001;
    tick();
    compared++;
    if (ready0 !== 1'b1) begin
      mismatched++;
      $display("FAIL zero_wait_latency: ready0=%b required 1", ready0);
    end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ready0 !== 1'b0) pulses++;
    end
    compared++;
    if (pulses != 0 || busy0 !== 1'b1) begin
      mismatched++;
      $display("FAIL zero_wait_hold: pulses=%0d busy0=%b required 0/1", pulses, busy0);
    end
    cpu_mio0 = 1'b0;
    tick();
    compared++;
    if (busy0 !== 1'b0) begin
      mismatched++;
      $display("FAIL zero_wait_release: busy0=%b required 0", busy0);
    end
    cpu_mio0 = 1'b1; mem_w0 = 1'b0; addr0 = 32'hD000_0004;
    tick();
    compared++;
    if (ready0 !== 1'b1 || rdata0 !== 32'hA5A5_0001) begin
      mismatched++;
      $display("FAIL zero_wait_read: ready0=%b rdata0=%h required 1/a5a50001", ready0, rdata0);
    end
    cpu_mio0 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_miss();
    do_miss(32'hE000_0000, "miss_e");
    do_access(32'h0000_0000 | 32'hD000_0000, 1'b0, 32'd0, 0, "miss_bank_unchanged");
  endtask

  task automatic test_reset_mid();
    int pulses;
    cpu_mio = 1'b1; mem_w = 1'b1; addr = 32'hD000_0008; wdata = 32'h0000_1234;
    tick();
    tick();
    rst = 1'b1;
    tick();
    compared++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid: ready=%b busy=%b required 0/0", ready, busy);
    end
    rst = 1'b0; cpu_mio = 1'b0;
    model_reset();
    pulses = 0;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      if (ready !== 1'b0) pulses++;
    end
    compared++;
    if (pulses != 0) begin
      mismatched++;
      $display("FAIL reset_mid_no_pulse: pulses=%0d required 0", pulses);
    end
    do_access(32'hD000_0008, 1'b0, 32'd0, 0, "reset_mid_idx2");
  endtask

  task automatic test_rst_hit();
    cpu_mio = 1'b1; mem_w = 1'b1; addr = 32'hD000_000C; wdata = 32'hFEED_0003;
    rst = 1'b1;
    tick();
    rst = 1'b0; cpu_mio = 1'b0;
    model_reset();
    tick();
    compared++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_hit: busy=%b ready=%b required 0/0", busy, ready);
    end
    do_access(32'hD000_000C, 1'b0, 32'd0, 0, "rst_hit_idx3");
  endtask

  task automatic test_early_drop();
    do_access(32'hD000_0014, 1'b1, 32'h0BAD_F00D, 1, "early_drop_wr");
    do_access(32'hD000_0014, 1'b0, 32'd0, 1, "early_drop_rd");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [3:0]  nib;
    for (int k = 0; k < 40; k++) begin
      a = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        nib = 4'($urandom_range(0, 14));
        if (nib >= 4'hD) nib = nib + 4'd1;
        a[31:28] = nib;
        do_miss(a, "rand_miss");
      end else begin
        a[31:28] = 4'hD;
        do_access(a, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 1)), "rand");
      end
    end
  endtask

  task automatic test_stats();
    do_access(32'hD000_0000, 1'b1, 32'h1111_1111, 0, "stats_wr0");
    do_access(32'hD000_0004, 1'b0, 32'd0, 0, "stats_rd1");
    do_access(32'hD000_003C, 1'b0, 32'd0, 0, "stats_rd15");
    do_access(32'hD000_003C, 1'b1, 32'h5555_5555, 0, "stats_clear");
    do_access(32'hD000_003C, 1'b0, 32'd0, 0, "stats_after_clear");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cpu_mio = 1'b0; mem_w = 1'b0; addr = 32'd0; wdata = 32'd0;
    cpu_mio0 = 1'b0; mem_w0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
    model_reset();
    tick();
    tick();
    test_reset();
    test_write_read();
    test_zero_wait();
    test_miss();
    test_reset_mid();
    test_rst_hit();
    test_early_drop();
    test_random();
    if (STATS) test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
